// File: rtl/bram_byte_access_unit_if.sv
// Core-side request/response channel of the BRAM byte access unit.
// The core drives the master side and the access unit is the slave.
interface bram_byte_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned BYTE_ADDR_WIDTH = ADDR_WIDTH + 2;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [1:0]                 req_size;
  logic                       req_unsigned;
  logic [BYTE_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]      req_wdata;
  logic                       resp_valid;
  logic                       resp_error;
  logic [DATA_WIDTH-1:0]      resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata
  );
endinterface

// File: rtl/bram_byte_access_unit.sv
// Byte/half/word load-store adapter in front of one word-wide BRAM port.
// Sub-word stores are done as read-modify-write since the BRAM has no byte enables.
module bram_byte_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  bram_byte_access_unit_if.slave core,
  output logic                   mem_readEnable,
  output logic                   mem_writeEnable,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]  mem_writeData,
  input  logic [DATA_WIDTH-1:0]  mem_readData
);
  localparam int unsigned BYTE_ADDR_WIDTH = ADDR_WIDTH + 2;
  localparam logic [1:0]  SIZE_BYTE       = 2'd0;
  localparam logic [1:0]  SIZE_HALF       = 2'd1;
  localparam logic [1:0]  SIZE_WORD       = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RMW, S_ACK} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [BYTE_ADDR_WIDTH-1:0] r_addr;
  logic [1:0]                 r_size;
  logic                       r_unsigned;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic                       r_err;

  logic                       w_req_err;
  logic                       w_accept;
  logic [DATA_WIDTH-1:0]      w_shifted;
  logic [DATA_WIDTH-1:0]      w_load_data;
  logic [DATA_WIDTH-1:0]      w_merged;

  assign w_accept = core.req_valid & core.req_ready;

  // Misaligned half/word or the reserved size code
  always_comb begin
    w_req_err = 1'b1;
    case (core.req_size)
      SIZE_BYTE: w_req_err = 1'b0;
      SIZE_HALF: w_req_err = core.req_addr[0];
      SIZE_WORD: w_req_err = |core.req_addr[1:0];
      default:   w_req_err = 1'b1;
    endcase
  end

  // Load alignment and extension from the latched request
  always_comb begin
    w_shifted   = mem_readData;
    w_load_data = mem_readData;
    case (r_size)
      SIZE_BYTE: begin
        w_shifted   = mem_readData >> {r_addr[1:0], 3'b000};
        w_load_data = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        w_shifted   = mem_readData >> {r_addr[1], 4'b0000};
        w_load_data = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

  // Read-modify-write merge: only the target lane(s) take the store data
  always_comb begin
    w_merged = mem_readData;
    if (r_size == SIZE_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_ACK;
          end else if (!core.req_write) begin
            w_state_nxt = S_LOAD;
          end else if (core.req_size == SIZE_WORD) begin
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_RMW;
          end
        end
      end
      S_LOAD:  w_state_nxt = S_IDLE;
      S_RMW:   w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset gates every strobe so an abandoned RMW never writes
  always_comb begin
    core.req_ready  = 1'b0;
    core.resp_valid = 1'b0;
    core.resp_error = 1'b0;
    core.resp_rdata = '0;
    mem_readEnable  = 1'b0;
    mem_writeEnable = 1'b0;
    mem_address     = r_addr[BYTE_ADDR_WIDTH-1:2];
    mem_writeData   = r_wdata;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          core.req_ready = 1'b1;
          mem_address    = core.req_addr[BYTE_ADDR_WIDTH-1:2];
          mem_writeData  = core.req_wdata;
          if (core.req_valid && !w_req_err) begin
            if (core.req_write && core.req_size == SIZE_WORD) begin
              mem_writeEnable = 1'b1;
            end else begin
              mem_readEnable = 1'b1;
            end
          end
        end
        S_LOAD: begin
          core.resp_valid = 1'b1;
          core.resp_rdata = w_load_data;
        end
        S_RMW: begin
          mem_writeEnable = 1'b1;
          mem_writeData   = w_merged;
        end
        S_ACK: begin
          core.resp_valid = 1'b1;
          core.resp_error = r_err;
        end
        default: ;
      endcase
    end
  end

  // Request latch, captured on the accept edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= core.req_addr;
      r_size     <= core.req_size;
      r_unsigned <= core.req_unsigned;
      r_wdata    <= core.req_wdata;
      r_err      <= w_req_err;
    end
  end
endmodule

// File: tb/tb_bram_byte_access_unit.sv
// Bench for bram_byte_access_unit: directed vector table, reset corner cases,
// and a randomized back-to-back run checked against a byte-array reference.
module tb_bram_byte_access_unit;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned BAW = AW + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          mem_readEnable;
  logic          mem_writeEnable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData;
  logic [DW-1:0] mem_readData;

  bram_byte_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_byte_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .core           (bus),
    .mem_readEnable (mem_readEnable),
    .mem_writeEnable(mem_writeEnable),
    .mem_address    (mem_address),
    .mem_writeData  (mem_writeData),
    .mem_readData   (mem_readData)
  );

  always #5 clock = ~clock;

  // BRAM port with registered read data
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_writeEnable === 1'b1) bram[mem_address] <= mem_writeData;
    if (mem_readEnable === 1'b1)  mem_readData <= bram[mem_address];
  end

  int en_cnt   = 0;
  int wr_cnt   = 0;
  int resp_cnt = 0;
  always @(posedge clock) begin
    if (mem_readEnable === 1'b1) en_cnt++;
    if (mem_writeEnable === 1'b1) begin
      en_cnt++;
      wr_cnt++;
    end
    if (bus.resp_valid === 1'b1) resp_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian lanes
  logic [7:0] ref_mem [0:(1<<BAW)-1];

  task automatic ref_exec(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [BAW-1:0] a, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd,
                          output int lat, output int nen);
    int nb;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((int'(a) % nb) != 0);
    rd  = '0;
    lat = 1;
    nen = 0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[BAW'(int'(a) + i)] = wd[8*i +: 8];
      lat = (nb == 4) ? 1 : 2;
      nen = (nb == 4) ? 1 : 2;
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[BAW'(int'(a) + i)]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd  = v;
      nen = 1;
    end
  endtask

  // One request: wait for ready, accept, then watch until ready returns
  task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [BAW-1:0] a, input logic [31:0] wd, input bit hold,
                      output int lat, output logic err, output logic [31:0] rd,
                      output int cyc, output int nresp, output int nen);
    int w;
    int e0;
    if (!hold) @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    #1;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 10) begin
      @(negedge clock); #1;
      w++;
    end
    lat = 0; err = 1'b0; rd = '0; cyc = -1; nresp = 0; nen = 0;
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    e0 = en_cnt;
    @(posedge clock); #1;
    if (!hold) bus.req_valid = 1'b0;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clock); #1;
      cyc++;
      if (bus.resp_valid === 1'b1) begin
        nresp++;
        lat = cyc;
        err = bus.resp_error;
        rd  = bus.resp_rdata;
      end
      if (bus.req_ready === 1'b1) break;
    end
    nen = en_cnt - e0;
  endtask

  typedef struct {
    string       nm;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [BAW-1:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nen;
  } vec_t;

  function automatic vec_t mk(string nm, logic wr, logic [1:0] sz, logic uns,
                              logic [BAW-1:0] a, logic [31:0] wd, int lat,
                              logic err, logic [31:0] rd, int nen);
    vec_t v;
    v.nm = nm; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
    v.lat = lat; v.err = err; v.rd = rd; v.nen = nen;
    return v;
  endfunction

  task automatic check_xact(input string nm, input int lat, input logic err,
                            input logic [31:0] rd, input int cyc, input int nresp,
                            input int nen, input int e_lat, input logic e_err,
                            input logic [31:0] e_rd, input int e_nen);
    chk({nm, " latency"}, lat, e_lat);
    chk({nm, " ready_gap"}, cyc, e_lat + 1);
    chk({nm, " resp_count"}, nresp, 1);
    chk({nm, " error"}, 32'(err), 32'(e_err));
    chk({nm, " rdata"}, rd, e_rd);
    chk({nm, " mem_enables"}, nen, e_nen);
  endtask

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, cyc, nresp, nen, e_lat, e_nen, w0, r0, r;
    logic        err, e_err, wr, uns;
    logic [1:0]  sz;
    logic [31:0] rd, e_rd, wd;
    logic [BAW-1:0] a;

    for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
    for (int i = 0; i < (1 << BAW); i++) ref_mem[i] = '0;

    vecs.push_back(mk("sw10",   1, 2, 0, 10'h010, 32'h8000_80F0, 1, 0, 32'h0000_0000, 1));
    vecs.push_back(mk("lw10",   0, 2, 0, 10'h010, 32'h0,         1, 0, 32'h8000_80F0, 1));
    vecs.push_back(mk("lb10",   0, 0, 0, 10'h010, 32'h0,         1, 0, 32'hFFFF_FFF0, 1));
    vecs.push_back(mk("lbu10",  0, 0, 1, 10'h010, 32'h0,         1, 0, 32'h0000_00F0, 1));
    vecs.push_back(mk("lh12",   0, 1, 0, 10'h012, 32'h0,         1, 0, 32'hFFFF_8000, 1));
    vecs.push_back(mk("lhu12",  0, 1, 1, 10'h012, 32'h0,         1, 0, 32'h0000_8000, 1));
    vecs.push_back(mk("lb11",   0, 0, 0, 10'h011, 32'h0,         1, 0, 32'hFFFF_FF80, 1));
    vecs.push_back(mk("sw20",   1, 2, 0, 10'h020, 32'h1122_3344, 1, 0, 32'h0000_0000, 1));
    vecs.push_back(mk("sb21",   1, 0, 0, 10'h021, 32'h1234_56AA, 2, 0, 32'h0000_0000, 2));
    vecs.push_back(mk("lw20a",  0, 2, 0, 10'h020, 32'h0,         1, 0, 32'h1122_AA44, 1));
    vecs.push_back(mk("sh22",   1, 1, 0, 10'h022, 32'hFFFF_BEEF, 2, 0, 32'h0000_0000, 2));
    vecs.push_back(mk("lw20b",  0, 2, 0, 10'h020, 32'h0,         1, 0, 32'hBEEF_AA44, 1));
    vecs.push_back(mk("lb23",   0, 0, 0, 10'h023, 32'h0,         1, 0, 32'hFFFF_FFBE, 1));
    vecs.push_back(mk("lhu20",  0, 1, 1, 10'h020, 32'h0,         1, 0, 32'h0000_AA44, 1));
    vecs.push_back(mk("lw21",   0, 2, 0, 10'h021, 32'h0,         1, 1, 32'h0000_0000, 0));
    vecs.push_back(mk("sh23",   1, 1, 0, 10'h023, 32'h0000_1234, 1, 1, 32'h0000_0000, 0));
    vecs.push_back(mk("ld_sz3", 0, 3, 0, 10'h020, 32'h0,         1, 1, 32'h0000_0000, 0));
    vecs.push_back(mk("st_sz3", 1, 3, 0, 10'h020, 32'hFFFF_FFFF, 1, 1, 32'h0000_0000, 0));
    vecs.push_back(mk("lh21",   0, 1, 0, 10'h021, 32'h0,         1, 1, 32'h0000_0000, 0));
    vecs.push_back(mk("lw20c",  0, 2, 0, 10'h020, 32'h0,         1, 0, 32'hBEEF_AA44, 1));
    vecs.push_back(mk("sw30",   1, 2, 0, 10'h030, 32'h0000_0000, 1, 0, 32'h0000_0000, 1));

    // Reset held with a request pending
    reset            = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      chk("reset req_ready", 32'(bus.req_ready), 0);
      chk("reset resp_valid", 32'(bus.resp_valid), 0);
      chk("reset resp_rdata", bus.resp_rdata, 0);
    end
    chk("reset mem_enables", en_cnt, 0);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("post-reset req_ready", 32'(bus.req_ready), 1);

    foreach (vecs[i]) begin
      xact(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, 1'b0,
           lat, err, rd, cyc, nresp, nen);
      check_xact(vecs[i].nm, lat, err, rd, cyc, nresp, nen,
                 vecs[i].lat, vecs[i].err, vecs[i].rd, vecs[i].nen);
    end

    // Reset lands on the RMW cycle of SB 0x55 @0x30
    @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 10'h030;
    bus.req_wdata    = 32'h0000_0055;
    #1;
    chk("rmw_rst ready", 32'(bus.req_ready), 1);
    w0 = wr_cnt;
    r0 = resp_cnt;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(negedge clock); #1;
    chk("rmw_rst in_rmw", 32'(mem_writeEnable), 1);
    reset = 1'b1;
    #1;
    chk("rmw_rst we_gated", 32'(mem_writeEnable), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rmw_rst writes", wr_cnt - w0, 0);
    chk("rmw_rst responses", resp_cnt - r0, 0);
    xact(1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 1'b0, lat, err, rd, cyc, nresp, nen);
    check_xact("lw30", lat, err, rd, cyc, nresp, nen, 1, 1'b0, 32'h0, 1);

    // Random mixed traffic with req_valid held high
    @(negedge clock); #1;
    for (int k = 0; k < 32; k++) begin
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a   = BAW'(10'h080 + 10'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd = $urandom;
      ref_exec(wr, sz, uns, a, wd, e_err, e_rd, e_lat, e_nen);
      xact(wr, sz, uns, a, wd, 1'b1, lat, err, rd, cyc, nresp, nen);
      check_xact($sformatf("rnd%0d", k), lat, err, rd, cyc, nresp, nen,
                 e_lat, e_err, e_rd, e_nen);
    end
    bus.req_valid = 1'b0;

    // Read back the random region to catch silent write corruption
    for (int k = 0; k < 4; k++) begin
      a = BAW'(10'h080 + 10'(4 * k));
      ref_exec(1'b0, 2'd2, 1'b0, a, 32'h0, e_err, e_rd, e_lat, e_nen);
      xact(1'b0, 2'd2, 1'b0, a, 32'h0, 1'b0, lat, err, rd, cyc, nresp, nen);
      check_xact($sformatf("final_lw%0d", k), lat, err, rd, cyc, nresp, nen,
                 e_lat, e_err, e_rd, e_nen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
